// File: rtl/pcstk_pkg.sv
// -----------------------------------------------------------------------------
// pcstk_pkg
// Shared definitions for the PC / return-stack unit:
//   - op_t      : operation encoding driven on pc_stack_unit.op
//   - PL_W_MAX  : widest supported polynomial-counted low PC field
//   - lfsr_next : successor function of the low PC field
// -----------------------------------------------------------------------------
package pcstk_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        STEP = 3'd1,
        JMP  = 3'd2,
        CALL = 3'd3,
        RET  = 3'd4,
        LDPG = 3'd5
    } op_t;

    localparam int PL_W_MAX = 7;

    // Shift right by one and insert XNOR of the two LSBs at the top bit of a
    // field 'width' bits wide. Starting from 0 this walks 2^width-1 values;
    // the all-ones value maps to itself (lock state). Callers pass the field
    // zero-extended to PL_W_MAX bits and truncate the result back.
    function automatic logic [PL_W_MAX-1:0] lfsr_next(
        input logic [PL_W_MAX-1:0] pl,
        input int                  width
    );
        logic [PL_W_MAX-1:0] r;
        r = pl >> 1;
        r[width-1] = ~(pl[0] ^ pl[1]);
        return r;
    endfunction

endpackage

// File: rtl/pcstk_lifo.sv
// -----------------------------------------------------------------------------
// pcstk_lifo
// Shift-register return stack, DEPTH entries of W bits, top at entry 0.
// A push onto a full stack drops the oldest entry and keeps the count at
// DEPTH; a pop from an empty stack leaves the count at 0. Both faults raise a
// one-cycle pulse in the cycle after the offending request.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push, pop   requests (never asserted together by the parent)
//   din         value pushed
//   top         current top entry (undefined content when empty)
//   count       number of valid entries, 0..DEPTH
//   full, empty count==DEPTH / count==0
//   ovf, unf    overflow / underflow pulses
// -----------------------------------------------------------------------------
module pcstk_lifo #(
    parameter int DEPTH = 5,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic [4:0]   count,
    output logic         full,
    output logic         empty,
    output logic         ovf,
    output logic         unf
);

    // Entry storage has no reset: contents are irrelevant while count is 0.
    logic [W-1:0] mem [DEPTH];
    logic [4:0]   count_reg;
    logic         ovf_reg;
    logic         unf_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end else if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem[i] <= mem[i+1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            ovf_reg <= push && full;
            unf_reg <= pop && empty;
            if (push && !full) begin
                count_reg <= count_reg + 5'd1;
            end else if (pop && !empty) begin
                count_reg <= count_reg - 5'd1;
            end
        end
    end

    assign top   = mem[0];
    assign count = count_reg;
    assign full  = (count_reg == 5'(DEPTH));
    assign empty = (count_reg == 5'd0);
    assign ovf   = ovf_reg;
    assign unf   = unf_reg;

endmodule

// File: rtl/pc_stack_unit.sv
// -----------------------------------------------------------------------------
// pc_stack_unit
// Program counter {pu, pl} with an LFSR-stepped low field, a one-shot page
// latch (LDPG) consumed by the next JMP/CALL, and a DEPTH-entry return stack.
// Every op completes in one cycle; results are visible the following cycle.
//
// Parameters: PL_W (6 or 7), PU_W, DEPTH (2..16)
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   op, tgt, pg       operation, low-field target, page for LDPG
//   pc                current {pu, pl}
//   depth, full, empty return-stack occupancy
//   ovf, unf          one-cycle stack fault pulses
//   err_clr           clears sticky error flags
//   err_ovf, err_unf  sticky error flags
// Build option: define PCSTK_STICKY_ERR_EN to enable the sticky error flags;
// otherwise they are constant 0 and err_clr is ignored.
// -----------------------------------------------------------------------------
module pc_stack_unit
    import pcstk_pkg::*;
#(
    parameter int PL_W  = 6,
    parameter int PU_W  = 4,
    parameter int DEPTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           op,
    input  logic [PL_W-1:0]      tgt,
    input  logic [PU_W-1:0]      pg,
    output logic [PU_W+PL_W-1:0] pc,
    output logic [4:0]           depth,
    output logic                 full,
    output logic                 empty,
    output logic                 ovf,
    output logic                 unf,
    input  logic                 err_clr,
    output logic                 err_ovf,
    output logic                 err_unf
);

    generate
        if (PL_W != 6 && PL_W != 7) begin : g_bad_pl_w
            $error("pc_stack_unit: PL_W must be 6 or 7");
        end
        if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
            $error("pc_stack_unit: DEPTH must be in 2..16");
        end
    endgenerate

    localparam int PC_W = PU_W + PL_W;

    logic [PU_W-1:0] pu_reg, pu_next;
    logic [PL_W-1:0] pl_reg, pl_next;
    logic [PU_W-1:0] pend_pg_reg, pend_pg_next;
    logic            pend_v_reg, pend_v_next;

    logic [PL_W-1:0] pl_step;
    logic [PU_W-1:0] dest_pu_jmp;
    logic [PU_W-1:0] dest_pu_call;
    logic            push, pop;
    logic [PC_W-1:0] stack_top;
    logic            stack_full, stack_empty;
    op_t             op_dec;

    assign op_dec       = op_t'(op);
    assign pl_step      = PL_W'(lfsr_next(PL_W_MAX'(pl_reg), PL_W));
    // A pending page overrides the destination page once; otherwise JMP stays
    // on the current page and CALL lands on the top page.
    assign dest_pu_jmp  = pend_v_reg ? pend_pg_reg : pu_reg;
    assign dest_pu_call = pend_v_reg ? pend_pg_reg : {PU_W{1'b1}};

    always_comb begin
        pu_next      = pu_reg;
        pl_next      = pl_reg;
        pend_pg_next = pend_pg_reg;
        pend_v_next  = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        case (op_dec)
            STEP: begin
                pl_next = pl_step;
            end
            JMP: begin
                pu_next = dest_pu_jmp;
                pl_next = tgt;
            end
            CALL: begin
                push    = 1'b1;
                pu_next = dest_pu_call;
                pl_next = tgt;
            end
            RET: begin
                pop = 1'b1;
                if (stack_empty) begin
                    {pu_next, pl_next} = '0;
                end else begin
                    {pu_next, pl_next} = stack_top;
                end
            end
            LDPG: begin
                // First LDPG of a run wins; later ones leave the latch alone.
                pend_v_next = 1'b1;
                if (!pend_v_reg) begin
                    pend_pg_next = pg;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pu_reg      <= '0;
            pl_reg      <= '0;
            pend_pg_reg <= '0;
            pend_v_reg  <= 1'b0;
        end else begin
            pu_reg      <= pu_next;
            pl_reg      <= pl_next;
            pend_pg_reg <= pend_pg_next;
            pend_v_reg  <= pend_v_next;
        end
    end

    pcstk_lifo #(
        .DEPTH (DEPTH),
        .W     (PC_W)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({pu_reg, pl_step}),
        .top   (stack_top),
        .count (depth),
        .full  (stack_full),
        .empty (stack_empty),
        .ovf   (ovf),
        .unf   (unf)
    );

    assign pc    = {pu_reg, pl_reg};
    assign full  = stack_full;
    assign empty = stack_empty;

`ifdef PCSTK_STICKY_ERR_EN
    logic err_ovf_reg;
    logic err_unf_reg;
    logic ovf_set;
    logic unf_set;

    // Set on the same edge that raises the pulse; a coincident clear loses.
    assign ovf_set = push && stack_full;
    assign unf_set = pop && stack_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf_reg <= 1'b0;
            err_unf_reg <= 1'b0;
        end else begin
            err_ovf_reg <= ovf_set | (err_ovf_reg & ~err_clr);
            err_unf_reg <= unf_set | (err_unf_reg & ~err_clr);
        end
    end

    assign err_ovf = err_ovf_reg;
    assign err_unf = err_unf_reg;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_ovf        = 1'b0;
    assign err_unf        = 1'b0;
`endif

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter PL_W, default 6: width of the polynomial-counted low PC field; legal values 6 or 7; any other value is an elaboration error.
REQ-002 Parameter PU_W, default 4: width of the page (upper PC) field.
REQ-003 Parameter DEPTH, default 5: number of return-stack entries; legal range 2..16.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 op  in  3  operation code: NOP, STEP, JMP, CALL, RET, LDPG; other codes act as NOP.
REQ-007 tgt  in  PL_W  low-field target for JMP and CALL.
REQ-008 pg  in  PU_W  page value for LDPG.
REQ-009 pc  out  PU_W+PL_W  current program counter as {pu,pl}.
REQ-010 depth  out  5  number of valid stack entries, 0..DEPTH.
REQ-011 full, empty  out  1 each  depth==DEPTH and depth==0 respectively.
REQ-012 ovf, unf  out  1 each  single-cycle pulses for stack overflow and underflow.
REQ-013 err_clr  in  1  clears the sticky error flags (REQ-030).
REQ-014 err_ovf, err_unf  out  1 each  sticky error flags (REQ-030).

Function
REQ-015 lfsr_next(pl) SHALL be {pl[0] XNOR pl[1], pl[PL_W-1:1]}, giving period 2^PL_W-1 from 0; the all-ones value is a lock state and maps to itself.
REQ-016 STEP SHALL set pl to lfsr_next(pl) and leave pu unchanged.
REQ-017 LDPG SHALL latch pg into pend_pg and set pend_v only if pend_v was 0, so the first of consecutive LDPGs wins.
REQ-018 Any op other than LDPG SHALL clear pend_v in the same cycle.
REQ-019 JMP SHALL load pc={pend_v ? pend_pg : pu, tgt}.
REQ-020 CALL SHALL push {pu, lfsr_next(pl)} and load pc={pend_v ? pend_pg : all-ones, tgt}.
REQ-021 CALL when full SHALL discard the oldest entry, keep depth at DEPTH, and pulse ovf for one cycle.
REQ-022 RET SHALL pop the top entry into pc and decrement depth.
REQ-023 RET when empty SHALL load pc=0, keep depth at 0, and pulse unf for one cycle.
REQ-024 Every op SHALL complete in one cycle; pc, depth and flags are visible on the following cycle.
REQ-025 ovf and unf SHALL be 0 in every cycle except the one following the faulting op.

Reset
REQ-026 While rst is high: pc=0, depth=0, empty=1, full=0, pend_v=0, ovf=unf=0, err_ovf=err_unf=0.
REQ-027 Stack entry contents are don't-care after reset; a RET on an empty stack always returns 0 regardless of them.
REQ-028 rst asserted mid-operation SHALL override any op issued in the same cycle.

Configuration
REQ-029 Macro PCSTK_STICKY_ERR_EN gates the sticky error logic.
REQ-030 With the macro defined: err_ovf/err_unf set on ovf/unf, hold until err_clr, and when set coincides with err_clr the set wins.
REQ-031 Without the macro: err_ovf/err_unf are tied to 0, err_clr is ignored, and no flops are generated for them.

Structure
REQ-032 Package pcstk_pkg SHALL hold the op encoding enum (NOP=0, STEP=1, JMP=2, CALL=3, RET=4, LDPG=5) and the lfsr_next function.
REQ-033 Sub-module pcstk_lifo SHALL implement the DEPTH x (PU_W+PL_W) push/pop shift-register stack with counter and ovf/unf generation.
REQ-034 pc_stack_unit SHALL contain the pc, page latch and op decode.

Verification (PL_W=6, PU_W=4, DEPTH=5, macro defined)
REQ-035 Reset, then STEP, STEP -> pc 0x000, 0x020, 0x030.
REQ-036 From pc=0x020, CALL tgt=0x15 -> pc=0x3D5, depth=1; then RET -> pc=0x030, depth=0, empty=1.
REQ-037 LDPG 3, LDPG 7, JMP tgt=0x01 -> pc=0x0C1; a following JMP tgt=0x02 -> pc=0x0C2 (page not reused).
REQ-038 Six CALLs -> depth=5, full=1, ovf pulses once on the sixth, err_ovf=1; six RETs -> sixth gives pc=0 and unf pulse; err_clr -> both flags 0.
REQ-039 JMP tgt=0x3F, then three STEPs -> pc low field stays 0x3F (lock state).
REQ-040 rst raised during a CALL cycle -> pc=0, depth=0, no ovf/unf pulse.
